// File: rtl/mem_access_unit_if.sv
// CPU-side load/store channel of the memory access unit.
// The master modport is the CPU issuing requests; the slave modport is the unit.
`timescale 1ns/1ps
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a 32-bit synchronous RAM whose
// read data arrives two cycles after the address. Sub-word stores are done as
// read-modify-write; misaligned or illegal-size requests complete with an error
// and never touch the RAM.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter     RAM_FILE   = "memory_init/eab-init-0"
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data,
  input  logic [31:0]           ram_q
);

  // The init file belongs to the RAM instance at the level above.
  localparam int unused_ram_file_bits = $bits(RAM_FILE);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT1,
    WAIT2,
    WRITE,
    RESP
  } state_t;

  state_t      state_reg;

  // captured request
  logic        write_reg;
  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] wdata_reg;

  // registered outputs
  logic        ram_we_reg;
  logic        resp_valid_reg;
  logic        resp_error_reg;
  logic [31:0] resp_rdata_reg;

  logic        accept;
  logic        req_bad;
  logic [7:0]  q_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged_data;

  // Only the low word-address bits and the low store lanes are consumed
  // after capture; the rest are held purely as part of the request record.
  logic unused_bits;
  assign unused_bits = ^{addr_reg[31:2], wdata_reg[31:16]};

  assign bus.req_ready  = (state_reg == IDLE) && !rst;
  assign accept         = bus.req_valid && bus.req_ready;

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_error = resp_error_reg;

  // A write must never reach the RAM in a reset cycle, even one that lands
  // while the RMW write is already on the bus.
  assign ram_we = ram_we_reg && !rst;

  // Alignment and size legality of the incoming request.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      SIZE_BYTE: req_bad = 1'b0;
      SIZE_HALF: req_bad = bus.req_addr[0];
      SIZE_WORD: req_bad = (bus.req_addr[1:0] != 2'b00);
      default:   req_bad = 1'b1;
    endcase
  end

  // Per-lane view of the read word and the RMW merge: the addressed lanes take
  // the store data, every other lane keeps what the RAM returned.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_wdata;

      assign q_bytes[gi] = ram_q[8*gi +: 8];

      assign lane_hit = (size_reg == SIZE_BYTE) ? (addr_reg[1:0] == 2'(gi))
                                                : (addr_reg[1] == 1'(gi / 2));

      assign lane_wdata = ((size_reg == SIZE_BYTE) || ((gi % 2) == 0)) ? wdata_reg[7:0]
                                                                       : wdata_reg[15:8];

      assign merged_data[8*gi +: 8] = lane_hit ? lane_wdata : q_bytes[gi];
    end
  endgenerate

  // Lane extraction and sign/zero extension of load data.
  always_comb begin
    byte_sel  = q_bytes[addr_reg[1:0]];
    half_sel  = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];
    load_data = ram_q;
    case (size_reg)
      SIZE_BYTE: load_data = unsigned_reg ? {24'h0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = unsigned_reg ? {16'h0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
      default:   load_data = ram_q;
    endcase
  end

  // Transaction sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      addr_reg       <= 32'h0;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      wdata_reg      <= 32'h0;
      ram_we_reg     <= 1'b0;
      ram_address    <= '0;
      ram_data       <= 32'h0;
      resp_valid_reg <= 1'b0;
      resp_error_reg <= 1'b0;
      resp_rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg    <= bus.req_write;
            addr_reg     <= bus.req_addr;
            size_reg     <= bus.req_size;
            unsigned_reg <= bus.req_unsigned;
            wdata_reg    <= bus.req_wdata;
            ram_address  <= bus.req_addr[ADDR_WIDTH+1:2];
            if (req_bad) begin
              // Faulting requests answer straight away without a RAM cycle.
              resp_valid_reg <= 1'b1;
              resp_error_reg <= 1'b1;
              resp_rdata_reg <= 32'h0;
              state_reg      <= RESP;
            end else if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
              ram_we_reg <= 1'b1;
              ram_data   <= bus.req_wdata;
              state_reg  <= ISSUE;
            end else begin
              // Loads and sub-word stores both start with a read.
              ram_we_reg <= 1'b0;
              state_reg  <= ISSUE;
            end
          end
        end

        ISSUE: begin
          ram_we_reg <= 1'b0;
          if (write_reg && (size_reg == SIZE_WORD)) begin
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= 32'h0;
            state_reg      <= RESP;
          end else begin
            state_reg <= WAIT1;
          end
        end

        WAIT1: begin
          state_reg <= WAIT2;
        end

        WAIT2: begin
          // ram_q now holds the addressed word.
          if (write_reg) begin
            ram_data   <= merged_data;
            ram_we_reg <= 1'b1;
            state_reg  <= WRITE;
          end else begin
            resp_rdata_reg <= load_data;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end
        end

        WRITE: begin
          ram_we_reg     <= 1'b0;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= 32'h0;
          state_reg      <= RESP;
        end

        RESP: begin
          resp_valid_reg <= 1'b0;
          resp_error_reg <= 1'b0;
          resp_rdata_reg <= 32'h0;
          state_reg      <= IDLE;
        end

        default: begin
          ram_we_reg     <= 1'b0;
          resp_valid_reg <= 1'b0;
          resp_error_reg <= 1'b0;
          resp_rdata_reg <= 32'h0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a two-cycle-latency RAM model, a word-array
// reference memory with arithmetic lane rules, directed scenarios and a
// randomized load/store mix.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data;
  logic [31:0]   ram_q;

  int checks = 0;
  int errors = 0;

  logic [31:0]   ram_mem [DEPTH];
  logic [AW-1:0] ram_addr_q;
  logic [31:0]   ref_mem [DEPTH];

  mem_access_unit_if bus ();

  mem_access_unit #(
    .ADDR_WIDTH(AW),
    .RAM_FILE  ("memory_init/eab-init-0")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_we     (ram_we),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // RAM with registered address and registered output (two-cycle read).
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address] <= ram_data;
    ram_addr_q <= ram_address;
    ram_q      <= ram_mem[ram_addr_q];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response fields idle at zero; no RAM write while in reset.
  always @(negedge clk) begin
    if (!bus.resp_valid) begin
      check("idle_rdata", bus.resp_rdata, 32'h0);
      check("idle_error", 32'(bus.resp_error), 32'h0);
    end
    if (rst) check("rst_we", 32'(ram_we), 32'h0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic is_err(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (addr % 2) != 0;
    if (size == 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int word_index(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] w;
    logic [31:0] v;
    w = ref_mem[word_index(addr)];
    if (size == 2'd0) begin
      v = (w >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] addr, input logic [1:0] size,
                                            input logic [31:0] wdata);
    logic [31:0] mask;
    int          sh;
    if (size == 2'd0) begin
      sh   = 8 * int'(addr % 4);
      mask = 32'hFF << sh;
    end else if (size == 2'd1) begin
      sh   = 16 * int'((addr / 2) % 2);
      mask = 32'hFFFF << sh;
    end else begin
      sh   = 0;
      mask = 32'hFFFF_FFFF;
    end
    return (ref_mem[word_index(addr)] & ~mask) | ((wdata << sh) & mask);
  endfunction

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  // One request/response; abort_at>0 asserts reset that many cycles after accept.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input int abort_at);
    logic          err;
    logic [31:0]   exp_rdata;
    logic [31:0]   new_word;
    int            exp_lat;
    int            lat;
    int            we_cnt;
    int            w;
    logic [AW-1:0] we_addr;
    logic [31:0]   we_data;
    err       = is_err(addr, size);
    exp_rdata = (err || wr) ? 32'h0 : ref_load(addr, size, uns);
    new_word  = ref_store(addr, size, wdata);
    exp_lat   = err ? 1 : (wr && size == 2'd2) ? 2 : wr ? 5 : 4;
    lat       = 0;
    we_cnt    = 0;
    we_addr   = '0;
    we_data   = 32'h0;

    @(negedge clk);
    drive_req(wr, addr, size, uns, wdata);
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid = 1'b0;
      if (abort_at == n) begin
        check("abort_no_we_before", 32'(we_cnt), 32'h0);
        rst = 1'b1;
        #1;
        check("abort_we_gated", 32'(ram_we), 32'h0);
        @(negedge clk);
        check("abort_no_resp", 32'(bus.resp_valid), 32'h0);
        check("abort_we_low", 32'(ram_we), 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        check("abort_no_resp_late", 32'(bus.resp_valid), 32'h0);
        $display("txn %s addr=0x%08h size=%0d aborted by reset at cycle %0d",
                 wr ? "ST" : "LD", addr, size, n);
        return;
      end
      if (ram_we) begin
        we_cnt++;
        we_addr = ram_address;
        we_data = ram_data;
      end
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", bus.resp_rdata, exp_rdata);
    check("error", 32'(bus.resp_error), 32'(err));
    check("we_count", 32'(we_cnt), (err || !wr) ? 32'h0 : 32'h1);
    if (we_cnt == 1) begin
      check("we_addr", 32'(we_addr), 32'(word_index(addr)));
      check("we_data", we_data, new_word);
    end
    if (wr && !err) ref_mem[word_index(addr)] = new_word;
    $display("txn %s addr=0x%08h size=%0d uns=%0d wdata=0x%08h lat=%0d rdata=0x%08h err=%0d",
             wr ? "ST" : "LD", addr, size, uns, wdata, lat, bus.resp_rdata, bus.resp_error);
  endtask

  initial begin
    logic [31:0] bb_addr [3];
    logic [1:0]  bb_size [3];
    logic        bb_uns  [3];
    logic [31:0] bb_exp  [3];
    int          acc_cyc [3];
    int          k;
    int          r;
    int          bad;
    logic        adv;
    logic [31:0] tmp;
    logic [31:0] lo;
    int          s;

    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram_q      = 32'h0;
    ram_addr_q = '0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_address", 32'(ram_address), 32'h0);
    check("rst_ram_data", ram_data, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_out_of_rst", 32'(bus.req_ready), 32'h1);

    // Word store then load
    run_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    run_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);

    // Byte store into a known word, signed and unsigned byte loads
    run_txn(1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344, 0);
    run_txn(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000AA, 0);
    run_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0);

    // Half store into a zero word, then loads
    run_txn(1'b1, 32'h22, 2'd1, 1'b0, 32'h00008001, 0);
    run_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h22, 2'd1, 1'b1, 32'h0, 0);

    // Faulting requests
    run_txn(1'b0, 32'h01, 2'd1, 1'b0, 32'h0, 0);
    run_txn(1'b1, 32'h06, 2'd2, 1'b0, 32'hCAFEF00D, 0);
    run_txn(1'b0, 32'h00, 2'd3, 1'b0, 32'h0, 0);
    run_txn(1'b1, 32'h03, 2'd1, 1'b0, 32'h1234, 0);

    // Reset during WAIT2 and during WRITE of a byte store; word must survive
    run_txn(1'b1, 32'h30, 2'd2, 1'b0, 32'h55667788, 0);
    run_txn(1'b1, 32'h31, 2'd0, 1'b0, 32'h000000EE, 3);
    run_txn(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 0);
    run_txn(1'b1, 32'h32, 2'd1, 1'b0, 32'h0000ABCD, 4);
    run_txn(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 0);

    // Address wrap: upper bits ignored
    run_txn(1'b1, 32'hFFFF_F404, 2'd2, 1'b0, 32'h0BADCAFE, 0);
    run_txn(1'b0, 32'h0000_0004, 2'd2, 1'b0, 32'h0, 0);

    // Three loads with req_valid held high
    for (int i = 0; i < 3; i++) begin
      bb_size[i] = 2'($urandom_range(0, 2));
      lo         = 32'($urandom_range(0, 63));
      if (bb_size[i] == 2'd1) lo = lo & ~32'h1;
      if (bb_size[i] == 2'd2) lo = lo & ~32'h3;
      bb_addr[i] = lo;
      bb_uns[i]  = 1'($urandom_range(0, 1));
      bb_exp[i]  = ref_load(bb_addr[i], bb_size[i], bb_uns[i]);
      acc_cyc[i] = 0;
    end
    @(negedge clk);
    drive_req(1'b0, bb_addr[0], bb_size[0], bb_uns[0], 32'h0);
    k   = 0;
    r   = 0;
    adv = 1'b0;
    for (int c = 0; c < 60 && r < 3; c++) begin
      if (adv) begin
        if (k < 3) drive_req(1'b0, bb_addr[k], bb_size[k], bb_uns[k], 32'h0);
        else bus.req_valid = 1'b0;
        adv = 1'b0;
      end
      if (bus.resp_valid) begin
        check("b2b_rdata", bus.resp_rdata, bb_exp[r]);
        check("b2b_error", 32'(bus.resp_error), 32'h0);
        $display("txn LD b2b #%0d addr=0x%08h size=%0d rdata=0x%08h", r, bb_addr[r], bb_size[r],
                 bus.resp_rdata);
        r++;
      end
      if (k < 3 && bus.req_valid && bus.req_ready) begin
        acc_cyc[k] = c;
        k++;
        adv = 1'b1;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", 32'(k), 32'h3);
    check("b2b_responses", 32'(r), 32'h3);
    check("b2b_spacing_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'h5);
    check("b2b_spacing_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'h5);

    // Randomized mix over a small window, with random upper address bits
    for (int t = 0; t < 60; t++) begin
      tmp = $urandom();
      s   = int'($urandom_range(0, 10));
      lo  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (s >= 4 && s < 7) lo = lo & ~32'h1;
        if (s >= 7) lo = lo & ~32'h3;
      end
      run_txn(1'($urandom_range(0, 1)), (tmp & 32'hFFFF_FC00) | lo,
              (s < 4) ? 2'd0 : (s < 7) ? 2'd1 : (s < 10) ? 2'd2 : 2'd3,
              1'($urandom_range(0, 1)), $urandom(), 0);
    end

    // RAM contents against reference memory
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== ref_mem[i]) bad++;
    check("ram_contents", 32'(bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM word-address width; RAM depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter RAM_FILE, default "memory_init/eab-init-0"; forwarded only by the instantiating level, unused internally.
REQ-003 clk  input  1  single clock; all state changes on posedge clk; RAM inclock and outclock tie to the same clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU load/store request present.
REQ-006 req_ready  output  1  unit can accept a request; transfer occurs when req_valid && req_ready at a posedge.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_wdata  input  32  store data, right-aligned (bits [7:0] byte, [15:0] half).
REQ-012 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_error  output  1  qualified by resp_valid; misaligned or illegal size.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 ram_address  output  ADDR_WIDTH  RAM word address.
REQ-017 ram_data  output  32  RAM write data.
REQ-018 ram_q  input  32  RAM read data; valid two cycles after address is presented with ram_we=0.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT1, WAIT2, WRITE, RESP; req_ready SHALL equal (state==IDLE && !rst).
REQ-020 On accept SHALL register write, addr, size, unsigned, wdata; requests while req_ready=0 SHALL be ignored.
REQ-021 Word address SHALL be req_addr[ADDR_WIDTH+1:2]; upper bits ignored, so addresses wrap modulo RAM size.
REQ-022 Error (half with addr[0]=1, word with addr[1:0]!=0, size 11): IDLE->RESP, resp_error=1, no RAM access, ram_we never asserted.
REQ-023 Word store: IDLE->ISSUE (ram_we=1, ram_data=wdata)->RESP; resp_valid 2 cycles after accept edge.
REQ-024 Load: IDLE->ISSUE (ram_we=0)->WAIT1->WAIT2; in WAIT2 SHALL capture ram_q lane-extracted and extended; ->RESP; resp_valid 4 cycles after accept.
REQ-025 Byte/half store (read-modify-write): ISSUE (ram_we=0)->WAIT1->WAIT2 (merge ram_q with wdata lanes)->WRITE (ram_we=1, merged data)->RESP; resp_valid 5 cycles after accept.
REQ-026 Lanes SHALL be little-endian: byte lane = addr[1:0], bits [8*addr[1:0]+7 : 8*addr[1:0]]; half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
REQ-027 Merge SHALL replace only the addressed lane(s); all other bits retain ram_q value.
REQ-028 ram_address SHALL hold the captured word address in ISSUE through WRITE; ram_we SHALL be 1 only in ISSUE (word store) and WRITE, and 0 whenever rst=1.
REQ-029 RESP SHALL last exactly one cycle then return to IDLE; a new request is acceptable in the cycle after RESP, giving back-to-back throughput of one request per (latency+1) cycles.
REQ-030 resp_rdata/resp_error SHALL be 0 whenever resp_valid=0.

Reset
REQ-031 When rst=1 at a posedge: state IDLE, resp_valid 0, resp_rdata 0, resp_error 0, ram_we 0, ram_address 0, ram_data 0, all captured request fields 0.
REQ-032 Reset mid-operation SHALL abandon the transaction with no response; a pending RMW write SHALL NOT reach the RAM; RAM contents are not cleared.

Verification
REQ-033 Word store 0xDEADBEEF @0x10, then word load @0x10 -> ram_we=1 at address 4 one cycle; load resp_rdata=0xDEADBEEF, resp_error=0, 4 cycles after accept.
REQ-034 Byte store 0xAA @0x13 over word 0x11223344 -> RAM word 0xAA223344; signed byte load @0x13 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-035 Half store 0x8001 @0x22 over 0x00000000 -> 0x80010000; signed half load @0x22 -> 0xFFFF8001; resp 5 cycles after store accept.
REQ-036 Half load @0x01, word store @0x06, size=11 @0x00 -> each resp_valid 1 cycle after accept, resp_error=1, resp_rdata=0, ram_we stays 0.
REQ-037 Byte store accepted, rst asserted during WAIT2 -> no resp_valid, ram_we never 1, target word unchanged; req_ready=1 the cycle after rst deasserts.
REQ-038 req_valid held high with 3 queued loads -> exactly one accept per 5 cycles, req_ready=0 between accepts, responses in order.
